// File: rtl/jkff_bank.sv
// -----------------------------------------------------------------------------
// jkff_bank
// Bank of WIDTH independent JK flip-flops used as a status/flag register.
// Each bit supports set (J), clear (K), toggle (J=K=1) and hold. The bank can
// be parallel-loaded. It reports which bits moved on the last edge and keeps
// two saturating activity counters for debug.
//
// Priority on every rising edge: rst > load > en > hold.
//
// Ports
//   clk      in   1      clock, all state updates on the rising edge
//   rst      in   1      synchronous active-high reset
//   en       in   1      enables JK evaluation for all channels
//   load     in   1      parallel load of d into q (overrides en/j/k)
//   d        in   WIDTH  parallel load data
//   j, k     in   WIDTH  per-channel J and K
//   cnt_clr  in   1      synchronous clear of both counters
//   q        out  WIDTH  registered state
//   qbar     out  WIDTH  ~q
//   changed  out  WIDTH  bit i set if q[i] changed on the last edge
//   tog_cnt  out  CNT_W  edges with at least one JK toggle, saturating
//   chg_cnt  out  CNT_W  total number of bit changes, saturating
// -----------------------------------------------------------------------------
module jkff_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] changed,
   output logic [CNT_W-1:0] tog_cnt,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_changed;
   logic [CNT_W-1:0] r_tog_cnt;
   logic [CNT_W-1:0] r_chg_cnt;

   logic [WIDTH-1:0] w_jk_next;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_diff;
   logic [CNT_W:0]   w_popcnt;
   logic [CNT_W:0]   w_chg_sum;
   logic [CNT_W-1:0] w_chg_next;
   logic [CNT_W-1:0] w_tog_next;
   logic             w_toggle_edge;

   // Per-channel JK next-state.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
         assign w_jk_next[gi] = (j[gi] & k[gi]) ? ~r_q[gi] :
                                j[gi]           ? 1'b1     :
                                k[gi]           ? 1'b0     :
                                                  r_q[gi];
      end
   endgenerate

   // Load overrides JK evaluation entirely; with en low j/k are ignored.
   assign w_q_next = load ? d : (en ? w_jk_next : r_q);
   assign w_diff   = w_q_next ^ r_q;

   // A toggle edge is counted only when JK evaluation really happens.
   assign w_toggle_edge = en & ~load & (|(j & k));

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_popcnt = w_popcnt + (CNT_W+1)'(w_diff[i]);
      end
   end

   // Sum one bit wider than the counter so an overflow clamps instead of wrapping.
   assign w_chg_sum  = {1'b0, r_chg_cnt} + w_popcnt;
   assign w_chg_next = (w_chg_sum > {1'b0, CNT_MAX}) ? CNT_MAX : w_chg_sum[CNT_W-1:0];
   assign w_tog_next = (w_toggle_edge && (r_tog_cnt != CNT_MAX)) ? r_tog_cnt + 1'b1 : r_tog_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= RESET_VAL;
         r_changed <= '0;
         r_tog_cnt <= '0;
         r_chg_cnt <= '0;
      end else begin
         r_q       <= w_q_next;
         r_changed <= w_diff;
         // Clear discards this edge's own increments.
         if (cnt_clr) begin
            r_tog_cnt <= '0;
            r_chg_cnt <= '0;
         end else begin
            r_tog_cnt <= w_tog_next;
            r_chg_cnt <= w_chg_next;
         end
      end
   end

   assign q       = r_q;
   assign qbar    = ~r_q;
   assign changed = r_changed;
   assign tog_cnt = r_tog_cnt;
   assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_jkff_bank.sv
// -----------------------------------------------------------------------------
// tb_jkff_bank
// Directed bench for jkff_bank. Two instances share every input: u8 (CNT_W=8)
// carries the main function checks, u4 (CNT_W=4) exposes counter saturation
// quickly. Both reset to 8'hA5.
// -----------------------------------------------------------------------------
module tb_jkff_bank;

   logic       clk = 1'b0;
   logic       rst, en, load, cnt_clr;
   logic [7:0] d, j, k;

   logic [7:0] q8, qbar8, changed8, tog8, chg8;
   logic [7:0] q4, qbar4, changed4;
   logic [3:0] tog4, chg4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   jkff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) u8 (
      .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
      .cnt_clr(cnt_clr), .q(q8), .qbar(qbar8), .changed(changed8),
      .tog_cnt(tog8), .chg_cnt(chg8)
   );

   jkff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
      .cnt_clr(cnt_clr), .q(q4), .qbar(qbar4), .changed(changed4),
      .tog_cnt(tog4), .chg_cnt(chg4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a vector, take one rising edge, sample 1 time unit later.
   task automatic edge_step(input logic r, input logic l, input logic e, input logic c,
                            input logic [7:0] dv, input logic [7:0] jv, input logic [7:0] kv);
      rst = r; load = l; en = e; cnt_clr = c; d = dv; j = jv; k = kv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; en = 1'b0; cnt_clr = 1'b0; d = '0; j = '0; k = '0;

      // Reset for two edges
      edge_step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      edge_step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      $display("txn reset: q=%h qbar=%h chg=%h tog=%0d cnt=%0d", q8, qbar8, changed8, tog8, chg8);
      check("rst_q", q8, 8'hA5);
      check("rst_qbar", qbar8, 8'h5A);
      check("rst_changed", changed8, 8'h00);
      check("rst_tog", tog8, 0);
      check("rst_chg", chg8, 0);
      check("rst_q_u4", q4, 8'hA5);

      // Load 00 with counter clear: q moves A5->00, counters discard the edge
      edge_step(0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
      $display("txn load00+clr: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("ld0_q", q8, 8'h00);
      check("ld0_changed", changed8, 8'hA5);
      check("ld0_chg", chg8, 0);

      // Set upper nibble, clear lower nibble
      edge_step(0, 0, 1, 0, 8'h00, 8'hF0, 8'h0F);
      $display("txn jk set/clr: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("jk1_q", q8, 8'hF0);
      check("jk1_changed", changed8, 8'hF0);
      check("jk1_chg", chg8, 4);
      check("jk1_tog", tog8, 0);

      // Toggle all
      edge_step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
      $display("txn jk toggle: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("jk2_q", q8, 8'h0F);
      check("jk2_qbar", qbar8, 8'hF0);
      check("jk2_changed", changed8, 8'hFF);
      check("jk2_tog", tog8, 1);
      check("jk2_chg", chg8, 12);

      // Hold with j=k=0
      edge_step(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      $display("txn jk hold: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("jk3_q", q8, 8'h0F);
      check("jk3_changed", changed8, 8'h00);
      check("jk3_chg", chg8, 12);

      // Load beats en with j=k=FF; no toggle counted
      edge_step(0, 1, 1, 0, 8'h3C, 8'hFF, 8'hFF);
      $display("txn load vs en: q=%h chg=%h tog=%0d cnt=%0d cnt4=%0d", q8, changed8, tog8, chg8, chg4);
      check("pri_q", q8, 8'h3C);
      check("pri_changed", changed8, 8'h33);
      check("pri_tog", tog8, 1);
      check("pri_chg", chg8, 16);
      check("pri_chg_u4_clamp", chg4, 15);

      // en=0: j ignored
      edge_step(0, 0, 0, 0, 8'h00, 8'hFF, 8'h00);
      $display("txn en0 hold: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("en0_q", q8, 8'h3C);
      check("en0_changed", changed8, 8'h00);
      check("en0_chg", chg8, 16);

      // Clear counters, then toggle bit 0 for 20 edges
      edge_step(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
      check("clr_tog_u4", tog4, 0);
      check("clr_chg_u4", chg4, 0);
      for (int n = 1; n <= 20; n++) begin
         edge_step(0, 0, 1, 0, 8'h00, 8'h01, 8'h01);
         $display("txn sat edge %0d: q=%h tog4=%0d cnt4=%0d tog8=%0d", n, q4, tog4, chg4, tog8);
         if (n == 14) begin
            check("sat14_tog4", tog4, 14);
            check("sat14_chg4", chg4, 14);
         end
         if (n == 15) begin
            check("sat15_tog4", tog4, 15);
            check("sat15_chg4", chg4, 15);
         end
      end
      check("sat20_tog4", tog4, 15);
      check("sat20_chg4", chg4, 15);
      check("sat20_tog8", tog8, 20);
      check("sat20_q", q8, 8'h3C);

      // cnt_clr together with a toggle edge
      edge_step(0, 0, 1, 1, 8'h00, 8'h01, 8'h01);
      $display("txn clr+toggle: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("clrtg_q", q8, 8'h3D);
      check("clrtg_changed", changed8, 8'h01);
      check("clrtg_tog", tog8, 0);
      check("clrtg_chg", chg8, 0);
      check("clrtg_tog_u4", tog4, 0);

      // chg_cnt clamp at 255 on the 8-bit counter: 31*8=248, then 248+8 -> 255
      for (int n = 1; n <= 31; n++) begin
         edge_step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
      end
      $display("txn all-toggle x31: q=%h tog=%0d cnt=%0d", q8, tog8, chg8);
      check("sat31_q", q8, 8'hC2);
      check("sat31_chg8", chg8, 248);
      edge_step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
      $display("txn all-toggle x32: q=%h tog=%0d cnt=%0d", q8, tog8, chg8);
      check("sat32_chg8", chg8, 255);
      check("sat32_tog8", tog8, 32);

      // Reset beats load on the same edge
      edge_step(1, 1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
      $display("txn rst+load: q=%h chg=%h tog=%0d cnt=%0d", q8, changed8, tog8, chg8);
      check("rstld_q", q8, 8'hA5);
      check("rstld_changed", changed8, 8'h00);
      check("rstld_tog", tog8, 0);
      check("rstld_chg", chg8, 0);

      // Resume after reset, idle edge
      edge_step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      $display("txn resume idle: q=%h chg=%h", q8, changed8);
      check("resume_q", q8, 8'hA5);
      check("resume_changed", changed8, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
